sequence_builder: RTL and testbench

SEQUENCE_BUILDER -- requirements
Module: sequence_builder

---
 rtl/sequence_builder.sv | 167 ++++++++++++++++
 tb/tb_sequence_builder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_builder.sv
// Colour-sequence memory with timed LED playback and player input check.
// Stores up to MAX_LEN random colours, shows them, then verifies presses.
module sequence_builder #(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] random_num,
  input  logic        new_game,
  input  logic        extend,
  input  logic        play,
  input  logic        btn_valid,
  input  logic [1:0]  btn_color,
  output logic        led_valid,
  output logic [1:0]  led_color,
  output logic [6:0]  seq_len,
  output logic        full,
  output logic        busy,
  output logic        play_done,
  output logic        match,
  output logic        mismatch,
  output logic        round_done
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_ON,
    SHOW_OFF,
    INPUT
  } state_t;

  state_t      state, state_nxt;
  logic [6:0]  len_nxt;
  logic [6:0]  index, index_nxt;
  logic [31:0] dwell, dwell_nxt;
  logic        pd_nxt, match_nxt;
  logic        mismatch_nxt, round_nxt;
  logic        we;
  logic [1:0]  mem [MAX_LEN];
  logic [1:0]  cur;
  logic        last;
  logic        unused;

  assign unused    = ^random_num[31:2];
  assign cur       = mem[index[AW-1:0]];
  assign last      = (index == seq_len - 7'd1);
  assign full      = (seq_len == 7'(MAX_LEN));
  assign busy      = (state != IDLE);
  assign led_valid = (state == SHOW_ON);
  assign led_color = led_valid ? cur : 2'd0;

  // Memory is cleared only logically through seq_len
  always_ff @(posedge clk) begin
    if (we) begin
      mem[seq_len[AW-1:0]] <= random_num[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      seq_len    <= 7'd0;
      index      <= 7'd0;
      dwell      <= 32'd0;
      play_done  <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      seq_len    <= len_nxt;
      index      <= index_nxt;
      dwell      <= dwell_nxt;
      play_done  <= pd_nxt;
      match      <= match_nxt;
      mismatch   <= mismatch_nxt;
      round_done <= round_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    len_nxt      = seq_len;
    index_nxt    = index;
    dwell_nxt    = dwell;
    pd_nxt       = 1'b0;
    match_nxt    = 1'b0;
    mismatch_nxt = 1'b0;
    round_nxt    = 1'b0;
    we           = 1'b0;
    if (new_game) begin
      state_nxt = IDLE;
      len_nxt   = 7'd0;
      index_nxt = 7'd0;
      dwell_nxt = 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (extend) begin
            if (!full) begin
              we      = 1'b1;
              len_nxt = seq_len + 7'd1;
            end
          end else if (play) begin
            if (seq_len == 7'd0) begin
              pd_nxt = 1'b1;
            end else begin
              index_nxt = 7'd0;
              dwell_nxt = 32'd0;
              state_nxt = SHOW_ON;
            end
          end
        end
        SHOW_ON: begin
          if (dwell == 32'(ON_CYCLES - 1)) begin
            dwell_nxt = 32'd0;
            state_nxt = SHOW_OFF;
          end else begin
            dwell_nxt = dwell + 32'd1;
          end
        end
        SHOW_OFF: begin
          if (dwell == 32'(OFF_CYCLES - 1)) begin
            dwell_nxt = 32'd0;
            if (index < seq_len - 7'd1) begin
              index_nxt = index + 7'd1;
              state_nxt = SHOW_ON;
            end else begin
              pd_nxt    = 1'b1;
              index_nxt = 7'd0;
              state_nxt = INPUT;
            end
          end else begin
            dwell_nxt = dwell + 32'd1;
          end
        end
        INPUT: begin
          if (btn_valid) begin
            unique case (1'b1)
              (btn_color == cur) && last: begin
                match_nxt = 1'b1;
                round_nxt = 1'b1;
                index_nxt = 7'd0;
                state_nxt = IDLE;
              end
              (btn_color == cur) && !last: begin
                match_nxt = 1'b1;
                index_nxt = index + 7'd1;
              end
              default: begin
                mismatch_nxt = 1'b1;
                index_nxt    = 7'd0;
                state_nxt    = IDLE;
              end
            endcase
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_builder.sv
// Directed bench for sequence_builder against a timeline model.
// Model tracks playback as elapsed cycles since play, not FSM states.
module tb_sequence_builder;

  localparam int ML  = 4;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int SLOT = ON + OFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] random_num = 32'd0;
  logic        new_game = 1'b0;
  logic        extend = 1'b0;
  logic        play = 1'b0;
  logic        btn_valid = 1'b0;
  logic [1:0]  btn_color = 2'd0;
  logic        led_valid;
  logic [1:0]  led_color;
  logic [6:0]  seq_len;
  logic        full, busy, play_done, match, mismatch, round_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sequence_builder #(
    .MAX_LEN(ML),
    .ON_CYCLES(ON),
    .OFF_CYCLES(OFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .random_num(random_num),
    .new_game(new_game),
    .extend(extend),
    .play(play),
    .btn_valid(btn_valid),
    .btn_color(btn_color),
    .led_valid(led_valid),
    .led_color(led_color),
    .seq_len(seq_len),
    .full(full),
    .busy(busy),
    .play_done(play_done),
    .match(match),
    .mismatch(mismatch),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {M_IDLE, M_PLAY, M_INPUT} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_len = 0;
  int         m_k = 0;
  int         m_pos = 0;
  logic [1:0] m_mem [ML];
  logic       m_pd = 0, m_match = 0, m_mm = 0, m_rd = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_len = 0;
      m_k = 0;
      m_pos = 0;
      m_pd = 0; m_match = 0; m_mm = 0; m_rd = 0;
    end else begin
      m_pd = 0; m_match = 0; m_mm = 0; m_rd = 0;
      if (new_game) begin
        m_mode = M_IDLE;
        m_len = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            if (extend) begin
              if (m_len < ML) begin
                m_mem[m_len] = random_num[1:0];
                m_len++;
              end
            end else if (play) begin
              if (m_len == 0) m_pd = 1;
              else begin
                m_mode = M_PLAY;
                m_k = 0;
              end
            end
          end
          M_PLAY: begin
            m_k++;
            if (m_k == SLOT * m_len) begin
              m_pd = 1;
              m_mode = M_INPUT;
              m_pos = 0;
            end
          end
          M_INPUT: begin
            if (btn_valid) begin
              if (btn_color == m_mem[m_pos]) begin
                m_match = 1;
                m_pos++;
                if (m_pos == m_len) begin
                  m_rd = 1;
                  m_mode = M_IDLE;
                end
              end else begin
                m_mm = 1;
                m_mode = M_IDLE;
              end
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  logic [14:0] exp_v, act_v;
  logic        e_lv;
  logic [1:0]  e_lc;

  always @(negedge clk) begin
    e_lv = (m_mode == M_PLAY) && ((m_k % SLOT) < ON);
    e_lc = 2'd0;
    if (e_lv) e_lc = m_mem[m_k / SLOT];
    exp_v = {e_lv, e_lc, 7'(m_len), (m_len == ML), (m_mode != M_IDLE),
             m_pd, m_match, m_mm, m_rd};
    act_v = {led_valid, led_color, seq_len, full, busy,
             play_done, match, mismatch, round_done};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL outputs cycle %0d: got %b want %b", cyc, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic ng, input logic ex, input logic pl,
                       input logic bv, input logic [1:0] bc,
                       input logic [31:0] rn);
    new_game = ng; extend = ex; play = pl;
    btn_valid = bv; btn_color = bc; random_num = rn;
    @(negedge clk);
    new_game = 0; extend = 0; play = 0; btn_valid = 0;
  endtask

  task automatic do_ext(input logic [31:0] rn);
    pulse(0, 1, 0, 0, 2'd0, rn);
  endtask

  task automatic do_play();
    pulse(0, 0, 1, 0, 2'd0, 32'd0);
  endtask

  task automatic press(input logic [1:0] c);
    pulse(0, 0, 0, 1, c, 32'd0);
  endtask

  task automatic do_new();
    pulse(1, 0, 0, 0, 2'd0, 32'd0);
  endtask

  task automatic play_run(input bit junk, input logic [7:0] colors);
    int p, delta;
    bit got, prev;
    logic [1:0] q[$];
    logic [7:0] packed_q;
    do_play();
    p = cyc;
    if (junk) begin
      do_ext(32'd1);
      do_play();
      press(2'd0);
    end
    got = 0;
    prev = 0;
    for (int i = 0; i < 60; i++) begin
      if (led_valid && !prev) q.push_back(led_color);
      prev = led_valid;
      if (play_done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("play_done_seen", 32'(got), 32'd1);
    delta = cyc - p;
    chk("play_done_delay", delta, 32'd24);
    chk("colour_count", q.size(), 32'd4);
    packed_q = 8'd0;
    foreach (q[i]) packed_q = {packed_q[5:0], q[i]};
    chk("colour_order", 32'(packed_q), 32'(colors));
  endtask

  initial begin
    int pd_cnt;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {led_valid, led_color, seq_len, full, busy,
        play_done, match, mismatch, round_done}, 32'd0);
    reset = 1'b1;

    do_ext(32'hB4BCD35C);
    chk("first_extend_len", seq_len, 32'd1);
    do_ext(32'h0000_0002);
    do_ext(32'h0000_0001);
    do_ext(32'h0000_0003);
    chk("len_after_four", seq_len, 32'd4);
    chk("full_after_four", full, 32'd1);

    play_run(1, 8'b00_10_01_11);
    press(2'd0);
    chk("press0_match", match, 32'd1);
    press(2'd2);
    chk("press1_match", match, 32'd1);
    press(2'd1);
    chk("press2_match", match, 32'd1);
    press(2'd3);
    chk("press3_match_round", {match, round_done, busy}, 32'b110);

    play_run(0, 8'b00_10_01_11);
    press(2'd0);
    chk("partial_match", match, 32'd1);
    press(2'd3);
    chk("wrong_mismatch", {match, mismatch}, 32'b01);
    chk("len_kept", seq_len, 32'd4);
    chk("idle_after_miss", busy, 32'd0);

    do_new();
    chk("new_game_len", seq_len, 32'd0);
    do_play();
    chk("empty_play_done", {play_done, busy}, 32'b10);

    do_ext(32'h3);
    do_ext(32'h0);
    do_ext(32'h2);
    do_ext(32'h1);
    do_ext(32'h2);
    chk("saturated_len", seq_len, 32'd4);
    chk("saturated_full", full, 32'd1);
    play_run(0, 8'b11_00_10_01);
    do_new();
    chk("new_game_in_input", {seq_len, busy, play_done, match,
        mismatch, round_done}, 32'd0);

    do_ext(32'h3);
    do_ext(32'h0);
    do_ext(32'h2);
    do_ext(32'h1);
    do_play();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", {led_valid, seq_len, busy}, 32'd0);
    pd_cnt = 0;
    @(negedge clk);
    if (play_done) pd_cnt++;
    @(negedge clk);
    if (play_done) pd_cnt++;
    reset = 1'b1;
    do_ext(32'h2);
    chk("first_cmd_after_release", seq_len, 32'd1);
    for (int i = 0; i < 30; i++) begin
      if (play_done) pd_cnt++;
      @(negedge clk);
    end
    chk("no_play_done_after_abort", pd_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
